// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU operand collector.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: collector state encoding, default queue entry layout,
// command constants for the single-operand commands, and req_ops(),
// which maps (MODE, CMD) to the operand-need mask {OPB, OPA}.
package alu_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int ALU_CMD_W = 4;

    // Arithmetic single-operand commands
    localparam int CMD_INC_A  = 4;
    localparam int CMD_DEC_A  = 5;
    localparam int CMD_INC_B  = 6;
    localparam int CMD_DEC_B  = 7;

    // Logical single-operand commands
    localparam int CMD_NOT_A  = 6;
    localparam int CMD_NOT_B  = 7;
    localparam int CMD_SHR1_A = 8;
    localparam int CMD_SHL1_A = 9;
    localparam int CMD_SHR1_B = 10;
    localparam int CMD_SHL1_B = 11;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] opa;
        logic [ALU_WIDTH-1:0] opb;
        logic [ALU_CMD_W-1:0] cmd;
        logic                 mode;
        logic                 cin;
        logic                 err;
    } alu_entry_t;

    // Returns {need_opb, need_opa}; every two-operand command needs both.
    function automatic logic [1:0] req_ops(input logic mode, input int cmd);
        logic [1:0] ops;
        ops = 2'b11;
        if (mode) begin
            case (cmd)
                CMD_INC_A, CMD_DEC_A: ops = 2'b01;
                CMD_INC_B, CMD_DEC_B: ops = 2'b10;
                default:              ops = 2'b11;
            endcase
        end else begin
            case (cmd)
                CMD_NOT_A, CMD_SHR1_A, CMD_SHL1_A: ops = 2'b01;
                CMD_NOT_B, CMD_SHR1_B, CMD_SHL1_B: ops = 2'b10;
                default:                           ops = 2'b11;
            endcase
        end
        return ops;
    endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// Synchronous FIFO of collector entries, DEPTH deep (power of two).
// Latency: a push at edge N is visible at the head right after edge N.
// Backpressure: push ignored when full, pop ignored when empty.
//
// Ports: i_clk, i_rst_n (async active-low), i_push/i_push_dat, i_pop,
//        o_head_dat (zero while empty), o_full, o_empty, o_count.
module alu_op_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = alu_entry_t
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  T                       i_push_dat,
    input  logic                   i_pop,
    output T                       o_head_dat,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    // Head is forced to zero while empty so stale storage never shows.
    assign o_head_dat = o_empty ? T'('0) : r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_operand_collector.sv
// Pairs OPA/OPB arriving in different cycles, times out missing operands, queues ops.
// Latency: a complete (or timed-out) op is at the queue head right after its capture edge.
// Backpressure: in_ready = queue not full; head held stable until out_ready.
//
// Ports: clk, rst (async active-low), CE (freezes capture/timer, not pops),
//        MODE/CMD/CIN/INP_VALID/OPA/OPB (operand side), in_ready,
//        out_valid/out_ready + out_opa/out_opb/out_cmd/out_mode/out_cin/out_err
//        (core side), busy (partial op held), count (queue occupancy).
module alu_operand_collector
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CMD_W   = 4,
    parameter int TIMEOUT = 16,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   CE,
    input  logic                   MODE,
    input  logic [CMD_W-1:0]       CMD,
    input  logic                   CIN,
    input  logic [1:0]             INP_VALID,
    input  logic [WIDTH-1:0]       OPA,
    input  logic [WIDTH-1:0]       OPB,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_opa,
    output logic [WIDTH-1:0]       out_opb,
    output logic [CMD_W-1:0]       out_cmd,
    output logic                   out_mode,
    output logic                   out_cin,
    output logic                   out_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
        logic [CMD_W-1:0] cmd;
        logic             mode;
        logic             cin;
        logic             err;
    } entry_t;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;

    // Partial-op capture registers (valid only in WAIT)
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [CMD_W-1:0] r_cmd;
    logic             r_mode;
    logic             r_cin;
    logic [1:0]       r_need;
    logic [1:0]       r_have;

    logic [1:0]       w_need_in;
    logic [1:0]       w_missing;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_latch;
    entry_t           w_push_ent;
    entry_t           w_head;

    assign w_need_in = req_ops(MODE, int'(CMD));
    assign w_missing = r_need & ~r_have;

    // Readiness deliberately ignores a same-cycle pop to keep the path short.
    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid && out_ready;
    assign busy      = (r_state == WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_push      = 1'b0;
        w_latch     = 1'b0;
        w_push_ent  = '0;
        case (r_state)
            IDLE: begin
                if (CE && in_ready && (INP_VALID != 2'b00)) begin
                    if ((INP_VALID & w_need_in) == w_need_in) begin
                        w_push          = 1'b1;
                        w_push_ent.opa  = w_need_in[0] ? OPA : '0;
                        w_push_ent.opb  = w_need_in[1] ? OPB : '0;
                        w_push_ent.cmd  = CMD;
                        w_push_ent.mode = MODE;
                        w_push_ent.cin  = CIN;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = WAIT;
                        w_timer_nxt = TMR_W'(1);
                    end
                end
            end
            WAIT: begin
                if (CE) begin
                    w_push_ent.cmd  = r_cmd;
                    w_push_ent.mode = r_mode;
                    w_push_ent.cin  = r_cin;
                    // Completion is checked first so it beats a same-cycle timeout.
                    if (in_ready && ((INP_VALID & w_missing) == w_missing)) begin
                        w_push         = 1'b1;
                        w_push_ent.opa = w_missing[0] ? OPA : r_opa;
                        w_push_ent.opb = w_missing[1] ? OPB : r_opb;
                        w_state_nxt    = IDLE;
                        w_timer_nxt    = '0;
                    end else if (r_timer >= TMR_W'(TIMEOUT - 1)) begin
                        if (in_ready) begin
                            w_push         = 1'b1;
                            w_push_ent.opa = r_opa;
                            w_push_ent.opb = r_opb;
                            w_push_ent.err = 1'b1;
                            w_state_nxt    = IDLE;
                            w_timer_nxt    = '0;
                        end else begin
                            // Queue full: park at TIMEOUT until a slot opens.
                            w_timer_nxt = TMR_W'(TIMEOUT);
                        end
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands outside the need mask are stored as zero so a timeout
    // entry carries zero for anything that never arrived.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_opa  <= '0;
            r_opb  <= '0;
            r_cmd  <= '0;
            r_mode <= 1'b0;
            r_cin  <= 1'b0;
            r_need <= 2'b00;
            r_have <= 2'b00;
        end else if (w_latch) begin
            r_opa  <= (INP_VALID[0] && w_need_in[0]) ? OPA : '0;
            r_opb  <= (INP_VALID[1] && w_need_in[1]) ? OPB : '0;
            r_cmd  <= CMD;
            r_mode <= MODE;
            r_cin  <= CIN;
            r_need <= w_need_in;
            r_have <= INP_VALID & w_need_in;
        end
    end

    alu_op_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_ent),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (count)
    );

    assign out_opa  = w_head.opa;
    assign out_opb  = w_head.opb;
    assign out_cmd  = w_head.cmd;
    assign out_mode = w_head.mode;
    assign out_cin  = w_head.cin;
    assign out_err  = w_head.err;

endmodule
